// File: rtl/fir8_const_filter.sv
// 8-tap direct-form FIR with fixed unsigned coefficients (reference datapath).
// Ports: clk, rst_n (async low), din[7:0] sample in, dout[15:0] registered sum.
module fir8_const_filter #(
  parameter int unsigned C0 = 1,
  parameter int unsigned C1 = 3,
  parameter int unsigned C2 = 5,
  parameter int unsigned C3 = 7,
  parameter int unsigned C4 = 7,
  parameter int unsigned C5 = 5,
  parameter int unsigned C6 = 3,
  parameter int unsigned C7 = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  din,
  output logic [15:0] dout
);

  localparam int NTAP = 8;

  localparam logic [7:0] LP_COEF [NTAP] = '{
    C0[7:0], C1[7:0], C2[7:0], C3[7:0],
    C4[7:0], C5[7:0], C6[7:0], C7[7:0]
  };

  logic [7:0]  r_tap [NTAP];
  logic [15:0] r_dout;

  logic [15:0] w_prod [NTAP];
  logic [18:0] w_sum;
  logic [2:0]  w_sum_unused_hi;
  logic [15:0] w_sum_lo;

  // 8 products of at most 16 bits each fit in 19 bits without loss.
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < NTAP; k++) begin
      w_prod[k] = 16'(LP_COEF[k]) * 16'(r_tap[k]);
      w_sum     = w_sum + 19'(w_prod[k]);
    end
  end

  // Output wraps modulo 2^16: only the low 16 bits are kept.
  assign {w_sum_unused_hi, w_sum_lo} = w_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NTAP; k++) begin
        r_tap[k] <= '0;
      end
      r_dout <= '0;
    end else begin
      r_tap[0] <= din;
      for (int k = 1; k < NTAP; k++) begin
        r_tap[k] <= r_tap[k-1];
      end
      r_dout <= w_sum_lo;
    end
  end

  assign dout = r_dout;

endmodule

// File: tb/tb_fir8_const_filter.sv
// Self-checking bench for fir8_const_filter: default and all-255 coefficients.
// Reference model is a convolution over the sample history since reset.
module tb_fir8_const_filter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  din = 'x;
  logic [15:0] dout;
  logic [15:0] dout_w;

  int checks = 0;
  int errors = 0;

  int unsigned hist [$];

  always #5 clk = ~clk;

  fir8_const_filter u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (din),
    .dout  (dout)
  );

  fir8_const_filter #(
    .C0(255), .C1(255), .C2(255), .C3(255),
    .C4(255), .C5(255), .C6(255), .C7(255)
  ) u_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (din),
    .dout  (dout_w)
  );

  // y = sum_k c[k] * x[n-1-k], mod 2^16; missing history counts as 0
  function automatic int unsigned model(input bit wide);
    int unsigned c [8];
    int unsigned s;
    if (wide) c = '{255, 255, 255, 255, 255, 255, 255, 255};
    else      c = '{1, 3, 5, 7, 7, 5, 3, 1};
    s = 0;
    for (int k = 0; k < 8; k++)
      if (k < hist.size()) s += c[k] * hist[k];
    return s % 65536;
  endfunction

  task automatic step(input logic [7:0] x, output logic [15:0] obs);
    int unsigned ea, ew;
    ea = model(1'b0);
    ew = model(1'b1);
    din = x;
    @(posedge clk);
    hist.push_front(int'(x));
    if (hist.size() > 8) void'(hist.pop_back());
    @(negedge clk);
    checks++;
    if (dout !== 16'(ea)) begin
      errors++;
      $display("FAIL model_dout: got %0d expected %0d", dout, ea);
    end
    checks++;
    if (dout_w !== 16'(ew)) begin
      errors++;
      $display("FAIL model_wrap: got %0d expected %0d", dout_w, ew);
    end
    obs = dout;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    din = 8'hFF;
    hist.delete();
    repeat (2) @(negedge clk);
    checks++;
    if (dout !== 16'd0 || dout_w !== 16'd0) begin
      errors++;
      $display("FAIL reset_hold: got %0d/%0d expected 0/0", dout, dout_w);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (dout !== 16'd0 || dout_w !== 16'd0) begin
      errors++;
      $display("FAIL reset_xdin: got %h/%h expected 0/0", dout, dout_w);
    end
    do_reset();
  endtask

  task automatic test_impulse();
    int unsigned exp_t [10] = '{0, 1, 3, 5, 7, 7, 5, 3, 1, 0};
    logic [15:0] obs;
    do_reset();
    for (int n = 0; n < 10; n++) begin
      step((n == 0) ? 8'd1 : 8'd0, obs);
      checks++;
      if (obs !== 16'(exp_t[n])) begin
        errors++;
        $display("FAIL impulse[%0d]: got %0d expected %0d", n, obs, exp_t[n]);
      end
    end
  endtask

  task automatic test_step();
    int unsigned exp_t [11] =
      '{0, 10, 40, 90, 160, 230, 280, 310, 320, 320, 320};
    logic [15:0] obs;
    do_reset();
    for (int n = 0; n < 11; n++) begin
      step(8'd10, obs);
      checks++;
      if (obs !== 16'(exp_t[n])) begin
        errors++;
        $display("FAIL step[%0d]: got %0d expected %0d", n, obs, exp_t[n]);
      end
    end
  endtask

  task automatic test_periodic();
    logic [7:0]  pat [8] = '{10, 2, 8, 2, 52, 21, 25, 1};
    logic [15:0] outs [32];
    logic [15:0] obs;
    do_reset();
    for (int n = 0; n < 32; n++) begin
      step(pat[n % 8], obs);
      outs[n] = obs;
    end
    for (int n = 8; n < 32; n += 8) begin
      checks++;
      if (outs[n] !== 16'd615) begin
        errors++;
        $display("FAIL periodic_615[%0d]: got %0d expected 615", n, outs[n]);
      end
    end
    for (int n = 16; n < 32; n++) begin
      checks++;
      if (outs[n] !== outs[n-8]) begin
        errors++;
        $display("FAIL period8[%0d]: got %0d expected %0d",
                 n, outs[n], outs[n-8]);
      end
    end
  endtask

  task automatic test_full_scale();
    logic [15:0] obs;
    do_reset();
    for (int n = 0; n < 12; n++) begin
      step(8'd255, obs);
      if (n >= 8) begin
        checks++;
        if (obs !== 16'd8160) begin
          errors++;
          $display("FAIL full_scale[%0d]: got %0d expected 8160", n, obs);
        end
        checks++;
        if (dout_w !== 16'd61448) begin
          errors++;
          $display("FAIL wrap[%0d]: got %0d expected 61448", n, dout_w);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] obs;
    for (int n = 0; n < 10; n++) step(8'(n * 20 + 5), obs);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dout !== 16'd0 || dout_w !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: got %0d/%0d expected 0/0", dout, dout_w);
    end
    hist.delete();
    din = 8'hFF;
    @(negedge clk);
    checks++;
    if (dout !== 16'd0) begin
      errors++;
      $display("FAIL async_hold: got %0d expected 0", dout);
    end
    rst_n = 1'b1;
    for (int n = 0; n < 10; n++) step(8'($urandom_range(255)), obs);
  endtask

  task automatic test_random();
    logic [15:0] obs;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      step(8'($urandom), obs);
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_step();
    test_periodic();
    test_full_scale();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir8_const_filter.md
Name: fir8_const_filter

Overview:
- 8-tap direct-form FIR filter with fixed, parameterised unsigned coefficients.
- Each clock it takes one unsigned 8-bit sample and produces one registered 16-bit filtered result.
- It is the reference ("given") datapath of the filter top level. Multiplierless/NEDA variants are checked against it sample-for-sample.

Parameters:
- C0, 1, coefficient for tap 0 (newest sample); unsigned, 8 bits max.
- C1, 3, coefficient for tap 1.
- C2, 5, coefficient for tap 2.
- C3, 7, coefficient for tap 3.
- C4, 7, coefficient for tap 4.
- C5, 5, coefficient for tap 5.
- C6, 3, coefficient for tap 6.
- C7, 1, coefficient for tap 7 (oldest sample).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  8  unsigned input sample, sampled every rising edge.
- dout  output  16  unsigned filtered output, registered.

Behaviour:
- Reset: while rst_n=0, all eight tap registers tap0..tap7 and dout are 0.
  - Reset takes effect asynchronously, immediately on assertion, including mid-stream.
  - din is ignored while in reset.
- Every rising edge with rst_n=1, the following updates happen simultaneously:
  - tap0 <= din
  - tapk <= tap(k-1) for k=1..7
  - dout <= sum over k of Ck*tapk, using the tap values from before this edge.
- Latency: a sample captured at edge e first contributes (times C0) to dout after edge e+1. It contributes times Ck after edge e+1+k.
  - Impulse response therefore appears on dout as C0..C7 on consecutive cycles.
- There is no handshake and no valid signal: one sample in and one result out per cycle, continuously.
- Arithmetic:
  - Products are unsigned 8x8 -> 16 bits.
  - Accumulation is done at 19 bits, and dout takes the low 16 bits.
  - Results wrap modulo 2^16. With the default coefficients the maximum is 255*32 = 8160, so no wrap occurs.
- Constant multiplies may be built from shifts/adds or from multipliers. Results must be bit-identical either way.
- Unknown din before reset release must not propagate, because taps are held at 0 during reset.
- After reset release, dout reflects partial sums until 8 samples have been captured. Unfilled taps count as 0.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with din=8'hFF -> dout=0. Assert rst_n=0 mid-stream -> dout drops to 0 immediately, without waiting for a clock edge.
- Impulse: din=1 for one cycle, then 0 -> dout sequence 1,3,5,7,7,5,3,1, then 0.
- Step: din=10 held after reset release -> dout 10,40,90,160,230,280,310,320, then constant 320.
- Periodic stream: repeat 10,2,8,2,52,21,25,1 one sample per cycle.
  - Steady state is periodic with period 8.
  - When tap0..tap7 = 1,25,21,52,2,8,2,10, dout on the next cycle = 615.
- Full scale: din=255 held -> dout settles at 8160 after 8 cycles. No overflow.
- Wrap: set all Ck=255 and drive din=255 -> steady dout = 520200 mod 65536 = 61448.
